dice_pip_scanner: RTL and testbench

DICE_PIP_SCANNER -- requirements
Module: dice_pip_scanner

---
 rtl/dice_pip_scanner.sv | 184 ++++++++++++++++++
 tb/tb_dice_pip_scanner.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dice_pip_scanner.sv
// ---------------------------------------------------------------------------
// dice_pip_scanner
//
// Scans a 3x3 dice pip matrix one row at a time and builds a 9-bit frame.
// A frame is accepted only after DEB_FRAMES identical frames in a row.
// An accepted frame that differs from the current pattern is published
// together with its decoded dice value and a legality flag.
//
// Parameters
//   SCAN_DIV    clock cycles each row stays driven (2..65535)
//   DEB_FRAMES  identical consecutive frames needed to accept (1..15)
//
// Ports
//   clk      in   single clock, all state changes on the rising edge
//   rst      in   asynchronous active-high reset
//   row_drv  out  one-hot row drive, bit0 = top row, bit2 = bottom row
//   col_sns  in   column sense (synchronous to clk), bit0 = left, 1 = lit
//   pattern  out  last accepted frame, bit index = row*3+col
//   count    out  dice value decoded from pattern (0 when illegal)
//   legal    out  1 when pattern is one of the eight legal dice faces
//   valid    out  one-cycle pulse when pattern/count/legal update
// ---------------------------------------------------------------------------
module dice_pip_scanner #(
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned DEB_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] row_drv,
    input  logic [2:0] col_sns,
    output logic [8:0] pattern,
    output logic [2:0] count,
    output logic       legal,
    output logic       valid
);

    localparam logic [15:0] DivLast   = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  DebTarget = 4'(DEB_FRAMES);

    typedef enum logic [1:0] {
        RowTop = 2'd0,
        RowMid = 2'd1,
        RowBot = 2'd2
    } rowSel_e;

    rowSel_e     rowSel_q,    rowSel_d;
    logic [15:0] divCnt_q,    divCnt_d;
    logic [5:0]  partial_q,   partial_d;
    logic [8:0]  prevFrame_q, prevFrame_d;
    logic [3:0]  runLen_q,    runLen_d;
    logic [8:0]  pattern_q,   pattern_d;
    logic [2:0]  count_q,     count_d;
    logic        legal_q,     legal_d;
    logic        valid_q,     valid_d;

    logic        sampleNow;
    logic [8:0]  frameNew;
    logic [3:0]  runNext;
    logic [3:0]  encNew;

    // Decodes a frame into {legal, count}; anything that is not one of the
    // eight recognised faces reports count 0 with legal cleared.
    function automatic logic [3:0] encodeFrame(input logic [8:0] f);
        logic [3:0] r;
        case (f)
            9'h000:  r = {1'b1, 3'd0};
            9'h010:  r = {1'b1, 3'd1};
            9'h101:  r = {1'b1, 3'd2};
            9'h111:  r = {1'b1, 3'd3};
            9'h145:  r = {1'b1, 3'd4};
            9'h155:  r = {1'b1, 3'd5};
            9'h16D:  r = {1'b1, 3'd6};
            9'h17D:  r = {1'b1, 3'd7};
            default: r = {1'b0, 3'd0};
        endcase
        return r;
    endfunction

    // The row dwell ends on the last divider count; the bottom row's columns
    // are taken straight from col_sns so the full frame is known on that edge.
    assign sampleNow = (divCnt_q == DivLast);
    assign frameNew  = {col_sns, partial_q};
    assign encNew    = encodeFrame(frameNew);

    // Run length of identical frames, saturating at the debounce target so
    // a long-held frame never wraps the counter.
    always_comb begin
        runNext = 4'd1;
        if (frameNew == prevFrame_q) begin
            if (runLen_q >= DebTarget) begin
                runNext = DebTarget;
            end else begin
                runNext = runLen_q + 4'd1;
            end
        end
    end

    // Next-state logic: divider, row sequencing, frame assembly, debounce
    // and commit. Outputs only move on a frame-completion edge that reaches
    // the debounce target with a frame different from the current pattern,
    // which is what suppresses repeat valid pulses.
    always_comb begin
        rowSel_d    = rowSel_q;
        divCnt_d    = divCnt_q + 16'd1;
        partial_d   = partial_q;
        prevFrame_d = prevFrame_q;
        runLen_d    = runLen_q;
        pattern_d   = pattern_q;
        count_d     = count_q;
        legal_d     = legal_q;
        valid_d     = 1'b0;

        if (sampleNow) begin
            divCnt_d = 16'd0;
            case (rowSel_q)
                RowTop: begin
                    partial_d[2:0] = col_sns;
                    rowSel_d       = RowMid;
                end
                RowMid: begin
                    partial_d[5:3] = col_sns;
                    rowSel_d       = RowBot;
                end
                RowBot: begin
                    rowSel_d    = RowTop;
                    prevFrame_d = frameNew;
                    runLen_d    = runNext;
                    if ((runNext == DebTarget) && (frameNew != pattern_q)) begin
                        pattern_d = frameNew;
                        count_d   = encNew[2:0];
                        legal_d   = encNew[3];
                        valid_d   = 1'b1;
                    end
                end
                default: begin
                    rowSel_d = RowTop;
                end
            endcase
        end
    end

    // State register. Reset drops any partial frame and debounce history so
    // scanning restarts cleanly on the top row with a full dwell.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rowSel_q    <= RowTop;
            divCnt_q    <= 16'd0;
            partial_q   <= 6'd0;
            prevFrame_q <= 9'd0;
            runLen_q    <= 4'd0;
            pattern_q   <= 9'd0;
            count_q     <= 3'd0;
            legal_q     <= 1'b1;
            valid_q     <= 1'b0;
        end else begin
            rowSel_q    <= rowSel_d;
            divCnt_q    <= divCnt_d;
            partial_q   <= partial_d;
            prevFrame_q <= prevFrame_d;
            runLen_q    <= runLen_d;
            pattern_q   <= pattern_d;
            count_q     <= count_d;
            legal_q     <= legal_d;
            valid_q     <= valid_d;
        end
    end

    // One-hot row drive decoded from the registered row index.
    always_comb begin
        row_drv = 3'b001;
        case (rowSel_q)
            RowTop:  row_drv = 3'b001;
            RowMid:  row_drv = 3'b010;
            RowBot:  row_drv = 3'b100;
            default: row_drv = 3'b001;
        endcase
    end

    assign pattern = pattern_q;
    assign count   = count_q;
    assign legal   = legal_q;
    assign valid   = valid_q;

endmodule

// File: tb/tb_dice_pip_scanner.sv
// ---------------------------------------------------------------------------
// tb_dice_pip_scanner
//
// Directed bench for dice_pip_scanner with SCAN_DIV=4, DEB_FRAMES=2.
// A small matrix model drives col_sns from row_drv and a held 9-bit face.
// Every cycle the row drive is compared against a cycle-count model; valid
// pulses are tallied and compared after each directed step.
// ---------------------------------------------------------------------------
module tb_dice_pip_scanner;

    localparam int unsigned ScanDiv   = 4;
    localparam int unsigned DebFrames = 2;
    localparam int          FrameLen  = 3 * ScanDiv;

    logic       clk;
    logic       rst;
    logic [2:0] row_drv;
    logic [2:0] col_sns;
    logic [8:0] pattern;
    logic [2:0] count;
    logic       legal;
    logic       valid;

    logic [8:0] stimFrame;
    int         errors;
    int         checks;
    int         tbCycle;
    int         pulses;
    int         lastPulse;
    int         baseCycle;

    logic [8:0] encPat [9];
    logic [2:0] encCnt [9];
    logic       encLeg [9];

    dice_pip_scanner #(
        .SCAN_DIV   (ScanDiv),
        .DEB_FRAMES (DebFrames)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .row_drv (row_drv),
        .col_sns (col_sns),
        .pattern (pattern),
        .count   (count),
        .legal   (legal),
        .valid   (valid)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Matrix model: the currently driven row sees its three bits of the face.
    always_comb begin
        col_sns = 3'b000;
        case (row_drv)
            3'b001:  col_sns = stimFrame[2:0];
            3'b010:  col_sns = stimFrame[5:3];
            3'b100:  col_sns = stimFrame[8:6];
            default: col_sns = 3'b000;
        endcase
    end

    // Hard stop in case the directed sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [8:0] face);
        stimFrame = face;
    endtask

    function automatic logic [2:0] expRow(input int cyc);
        case ((cyc / 4) % 3)
            0:       return 3'b001;
            1:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    // Advance one clock, sample 1 unit after the edge, check row drive and
    // record any valid pulse.
    task automatic stepCycle();
        @(posedge clk);
        #1;
        tbCycle++;
        checkOutput("row_drv", {13'd0, row_drv}, {13'd0, expRow(tbCycle)});
        if (valid === 1'b1) begin
            pulses++;
            lastPulse = tbCycle;
        end
    endtask

    task automatic runCycles(input int n);
        pulses    = 0;
        lastPulse = -1;
        for (int i = 0; i < n; i++) begin
            stepCycle();
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_row"},     {13'd0, row_drv}, 16'h0001);
        checkOutput({tag, "_valid"},   {15'd0, valid},   16'h0000);
        checkOutput({tag, "_pattern"}, {7'd0, pattern},  16'h0000);
        checkOutput({tag, "_count"},   {13'd0, count},   16'h0000);
        checkOutput({tag, "_legal"},   {15'd0, legal},   16'h0001);
    endtask

    task automatic checkCommit(input string tag, input int expPulseAt,
                               input logic [8:0] expPat, input logic [2:0] expCnt,
                               input logic expLeg);
        checkOutput({tag, "_pulses"},    16'(pulses),    16'd1);
        checkOutput({tag, "_pulseAt"},   16'(lastPulse), 16'(expPulseAt));
        checkOutput({tag, "_pattern"},   {7'd0, pattern}, {7'd0, expPat});
        checkOutput({tag, "_count"},     {13'd0, count},  {13'd0, expCnt});
        checkOutput({tag, "_legal"},     {15'd0, legal},  {15'd0, expLeg});
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        tbCycle   = 0;
        pulses    = 0;
        lastPulse = -1;
        stimFrame = 9'h000;

        encPat[0] = 9'h000; encCnt[0] = 3'd0; encLeg[0] = 1'b1;
        encPat[1] = 9'h010; encCnt[1] = 3'd1; encLeg[1] = 1'b1;
        encPat[2] = 9'h101; encCnt[2] = 3'd2; encLeg[2] = 1'b1;
        encPat[3] = 9'h111; encCnt[3] = 3'd3; encLeg[3] = 1'b1;
        encPat[4] = 9'h145; encCnt[4] = 3'd4; encLeg[4] = 1'b1;
        encPat[5] = 9'h155; encCnt[5] = 3'd5; encLeg[5] = 1'b1;
        encPat[6] = 9'h16D; encCnt[6] = 3'd6; encLeg[6] = 1'b1;
        encPat[7] = 9'h17D; encCnt[7] = 3'd7; encLeg[7] = 1'b1;
        encPat[8] = 9'h003; encCnt[8] = 3'd0; encLeg[8] = 1'b0;

        // Reset state held across several clock edges.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkIdleOutputs("reset");
        rst     = 1'b0;
        tbCycle = 0;
        checkOutput("release_row", {13'd0, row_drv}, 16'h0001);

        // Blank matrix: row rotation with 4-cycle dwell, no valid.
        applyStimulus(9'h000);
        runCycles(3 * FrameLen);
        checkOutput("blank_pulses", 16'(pulses), 16'd0);
        checkOutput("blank_pattern", {7'd0, pattern}, 16'h0000);
        checkOutput("blank_count", {13'd0, count}, 16'h0000);
        checkOutput("blank_legal", {15'd0, legal}, 16'h0001);

        // Five face: commits at the end of its second frame, then stays quiet.
        baseCycle = tbCycle;
        applyStimulus(9'h155);
        runCycles(2 * FrameLen);
        checkCommit("five", baseCycle + 2 * FrameLen, 9'h155, 3'd5, 1'b1);
        checkOutput("five_validNow", {15'd0, valid}, 16'h0001);
        runCycles(2 * FrameLen);
        checkOutput("five_hold_pulses", 16'(pulses), 16'd0);

        // All pips lit: illegal face still commits.
        baseCycle = tbCycle;
        applyStimulus(9'h1FF);
        runCycles(2 * FrameLen);
        checkCommit("allLit", baseCycle + 2 * FrameLen, 9'h1FF, 3'd0, 1'b0);

        // Alternating four/six faces never debounce.
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(9'h145);
            for (int c = 0; c < FrameLen; c++) stepCycle();
            applyStimulus(9'h16D);
            for (int c = 0; c < FrameLen; c++) stepCycle();
        end
        checkOutput("alt_pulses", 16'(pulses), 16'd0);
        checkOutput("alt_pattern", {7'd0, pattern}, 16'h01FF);

        // Five committed, then blank matrix returns the zero face.
        baseCycle = tbCycle;
        applyStimulus(9'h155);
        runCycles(2 * FrameLen);
        checkCommit("five2", baseCycle + 2 * FrameLen, 9'h155, 3'd5, 1'b1);
        baseCycle = tbCycle;
        applyStimulus(9'h000);
        runCycles(2 * FrameLen);
        checkCommit("toZero", baseCycle + 2 * FrameLen, 9'h000, 3'd0, 1'b1);

        // Three face interrupted by reset during row 1 of its committing frame.
        applyStimulus(9'h111);
        runCycles(FrameLen + 5);
        checkOutput("preRst_pulses", 16'(pulses), 16'd0);
        checkOutput("preRst_row", {13'd0, row_drv}, 16'h0002);
        rst = 1'b1;
        #1;
        checkIdleOutputs("midRst");
        repeat (2) @(negedge clk);
        checkIdleOutputs("midRstHeld");
        rst     = 1'b0;
        tbCycle = 0;
        runCycles(2 * FrameLen);
        checkCommit("afterRst", 2 * FrameLen, 9'h111, 3'd3, 1'b1);

        // Walk every legal face plus one illegal face through the decoder.
        for (int k = 0; k < 9; k++) begin
            baseCycle = tbCycle;
            applyStimulus(encPat[k]);
            runCycles(2 * FrameLen);
            checkCommit($sformatf("enc%0d", k), baseCycle + 2 * FrameLen,
                        encPat[k], encCnt[k], encLeg[k]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
